// File: rtl/crlb_chan_sched.sv
// rtl/crlb_chan_sched.sv - acquisition scheduler picking the strongest of four correlator channels
//
// Accumulates |crlb_k| over NSYM symbol strobes, then walks the four sums
// one per cycle to find the largest (ties resolve to the lowest index).
//
// Ports:
//   C         clock, rising edge
//   Reset_l   asynchronous active-low reset
//   start     run request, sampled only in IDLE
//   sym_stb   one-cycle symbol strobe; crlb0..crlb3 valid with it
//   crlb0..3  signed correlator outputs, RINT bits each
//   busy      high in CLEAR, ACCUM, COMPARE
//   done      one-cycle pulse in DONE
//   ch_sel    index of strongest channel (updated on DONE entry)
//   best_val  accumulated magnitude of ch_sel (updated on DONE entry)
//   lock      best_val >= THR (updated on DONE entry)
module crlb_chan_sched #(
    parameter int R    = 7,
    parameter int RINT = 4*R+1,
    parameter int NSYM = 16,
    parameter int CW   = $clog2(NSYM)+1,
    parameter int ACCW = RINT+$clog2(NSYM),
    parameter int THR  = 1024
) (
    input  logic                   C,
    input  logic                   Reset_l,
    input  logic                   start,
    input  logic                   sym_stb,
    input  logic signed [RINT-1:0] crlb0,
    input  logic signed [RINT-1:0] crlb1,
    input  logic signed [RINT-1:0] crlb2,
    input  logic signed [RINT-1:0] crlb3,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             ch_sel,
    output logic [ACCW-1:0]        best_val,
    output logic                   lock
);

    localparam logic [ACCW-1:0] THR_V = ACCW'(THR);
    localparam logic [CW-1:0]   LAST  = CW'(NSYM-1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t state, nxt;

    logic signed [RINT-1:0] crlb_a [4];
    logic signed [RINT:0]   ext    [4];
    logic [ACCW-1:0]        mag    [4];
    logic [ACCW-1:0]        acc    [4];
    logic [CW-1:0]          cnt;
    logic [1:0]             cmp_k;
    logic [1:0]             cand_idx;
    logic [ACCW-1:0]        cand_val;
    logic [1:0]             fin_idx;
    logic [ACCW-1:0]        fin_val;

    assign crlb_a[0] = crlb0;
    assign crlb_a[1] = crlb1;
    assign crlb_a[2] = crlb2;
    assign crlb_a[3] = crlb3;

    // Magnitude taken one bit wider than the input so the most negative
    // code negates to a positive value instead of wrapping.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            ext[k] = {crlb_a[k][RINT-1], crlb_a[k]};
            if (ext[k] < 0)
                mag[k] = ACCW'($unsigned(-ext[k]));
            else
                mag[k] = ACCW'($unsigned(ext[k]));
        end
    end

    // One compare step; on the last step this is also the final winner,
    // which lets the outputs load on the same edge that enters DONE.
    always_comb begin
        fin_idx = cand_idx;
        fin_val = cand_val;
        if (cmp_k == 2'd0) begin
            fin_idx = 2'd0;
            fin_val = acc[0];
        end else if (acc[cmp_k] > cand_val) begin
            fin_idx = cmp_k;
            fin_val = acc[cmp_k];
        end
    end

    always_ff @(posedge C or negedge Reset_l) begin
        if (!Reset_l)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt  = state;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_IDLE: begin
                if (start)
                    nxt = S_CLEAR;
            end
            S_CLEAR: begin
                busy = 1'b1;
                nxt  = S_ACCUM;
            end
            S_ACCUM: begin
                busy = 1'b1;
                if (sym_stb && cnt == LAST)
                    nxt = S_COMPARE;
            end
            S_COMPARE: begin
                busy = 1'b1;
                if (cmp_k == 2'd3)
                    nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                nxt  = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge C or negedge Reset_l) begin
        if (!Reset_l) begin
            for (int k = 0; k < 4; k++)
                acc[k] <= '0;
            cnt      <= '0;
            cmp_k    <= '0;
            cand_idx <= '0;
            cand_val <= '0;
            ch_sel   <= '0;
            best_val <= '0;
            lock     <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    for (int k = 0; k < 4; k++)
                        acc[k] <= '0;
                    cnt   <= '0;
                    cmp_k <= '0;
                end
                S_ACCUM: begin
                    if (sym_stb) begin
                        for (int k = 0; k < 4; k++)
                            acc[k] <= acc[k] + mag[k];
                        cnt <= cnt + CW'(1);
                    end
                end
                S_COMPARE: begin
                    cand_idx <= fin_idx;
                    cand_val <= fin_val;
                    cmp_k    <= cmp_k + 2'd1;
                    if (cmp_k == 2'd3) begin
                        ch_sel   <= fin_idx;
                        best_val <= fin_val;
                        lock     <= (fin_val >= THR_V);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crlb_chan_sched.sv
// tb/tb_crlb_chan_sched.sv - directed scoreboard bench for crlb_chan_sched
module tb_crlb_chan_sched;

    localparam int R    = 7;
    localparam int RINT = 4*R+1;
    localparam int NSYM = 4;
    localparam int ACCW = RINT+$clog2(NSYM);
    localparam int THR  = 1024;

    logic                   C = 1'b0;
    logic                   Reset_l = 1'b0;
    logic                   start = 1'b0;
    logic                   sym_stb = 1'b0;
    logic signed [RINT-1:0] crlb0 = '0;
    logic signed [RINT-1:0] crlb1 = '0;
    logic signed [RINT-1:0] crlb2 = '0;
    logic signed [RINT-1:0] crlb3 = '0;
    logic                   busy;
    logic                   done;
    logic [1:0]             ch_sel;
    logic [ACCW-1:0]        best_val;
    logic                   lock;

    crlb_chan_sched #(.R(R), .NSYM(NSYM), .THR(THR)) dut (
        .C        (C),
        .Reset_l  (Reset_l),
        .start    (start),
        .sym_stb  (sym_stb),
        .crlb0    (crlb0),
        .crlb1    (crlb1),
        .crlb2    (crlb2),
        .crlb3    (crlb3),
        .busy     (busy),
        .done     (done),
        .ch_sel   (ch_sel),
        .best_val (best_val),
        .lock     (lock)
    );

    always #5 C = ~C;

    typedef struct {
        logic [1:0]  idx;
        logic [63:0] val;
        logic        lk;
    } exp_t;

    exp_t   sb[$];
    longint macc[4];
    int     vectors = 0;
    int     miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge C);
    endtask

    task automatic scramble();
        crlb0 = RINT'($urandom);
        crlb1 = RINT'($urandom);
        crlb2 = RINT'($urandom);
        crlb3 = RINT'($urandom);
    endtask

    task automatic start_run(input bit clr_stb);
        for (int k = 0; k < 4; k++)
            macc[k] = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_in_clear", {63'd0, busy}, 64'd1);
        if (clr_stb) begin
            sym_stb = 1'b1;
            crlb0 = RINT'(1000);
            crlb1 = RINT'(1000);
            crlb2 = RINT'(1000);
            crlb3 = RINT'(1000);
        end
        tick();
        sym_stb = 1'b0;
        scramble();
        chk("busy_in_accum", {63'd0, busy}, 64'd1);
    endtask

    task automatic strobe(input longint a, input longint b, input longint c, input longint d,
                          input bit pulse_start);
        longint v[4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int k = 0; k < 4; k++)
            macc[k] += (v[k] < 0) ? -v[k] : v[k];
        crlb0 = RINT'(a);
        crlb1 = RINT'(b);
        crlb2 = RINT'(c);
        crlb3 = RINT'(d);
        sym_stb = 1'b1;
        start   = pulse_start;
        tick();
        sym_stb = 1'b0;
        start   = 1'b0;
        scramble();
    endtask

    task automatic finish_run();
        exp_t e;
        e.idx = 2'd0;
        e.val = 64'(macc[0]);
        for (int k = 1; k < 4; k++)
            if (64'(macc[k]) > e.val) begin
                e.idx = 2'(k);
                e.val = 64'(macc[k]);
            end
        e.lk = (e.val >= 64'(THR));
        sb.push_back(e);
    endtask

    // Entered at the negedge just after the edge that took the last strobe.
    task automatic wait_done(input logic [1:0] prev_sel, input bit pulse_start);
        int   n;
        exp_t e;
        n = 1;
        while (done !== 1'b1 && n < 12) begin
            chk("sel_hold", {62'd0, ch_sel}, {62'd0, prev_sel});
            sym_stb = 1'b1;
            scramble();
            start = (pulse_start && n == 2);
            tick();
            start = 1'b0;
            n++;
        end
        sym_stb = 1'b0;
        chk("done_latency", 64'(n), 64'd5);
        chk("done_seen", {63'd0, done}, 64'd1);
        if (done === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            chk("ch_sel", {62'd0, ch_sel}, {62'd0, e.idx});
            chk("best_val", 64'(best_val), e.val);
            chk("lock", {63'd0, lock}, {63'd0, e.lk});
            chk("busy_in_done", {63'd0, busy}, 64'd0);
        end
        tick();
        chk("done_pulse_end", {63'd0, done}, 64'd0);
        chk("busy_after_done", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        scramble();
        tick();
        tick();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_ch_sel", {62'd0, ch_sel}, 64'd0);
        chk("rst_best_val", 64'(best_val), 64'd0);
        chk("rst_lock", {63'd0, lock}, 64'd0);
        Reset_l = 1'b1;
        tick();

        // basic run: channel 2 wins with 1200
        start_run(1'b0);
        repeat (4) strobe(100, 200, -300, 50, 1'b0);
        finish_run();
        wait_done(2'd0, 1'b0);

        // all equal: lowest index wins, below threshold
        start_run(1'b0);
        repeat (4) strobe(77, 77, 77, 77, 1'b0);
        finish_run();
        wait_done(2'd2, 1'b0);

        // most negative input magnitude must not wrap
        start_run(1'b0);
        repeat (4) strobe(0, -(64'sd1 <<< 28), 0, 0, 1'b0);
        finish_run();
        wait_done(2'd0, 1'b0);
        chk("extreme_val", 64'(best_val), 64'd1 << 30);

        // strobe during CLEAR ignored; gapped strobes
        start_run(1'b1);
        strobe(10, -20, 30, -5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(3, 10)) tick();
            strobe(10 + i, -20, 30, -5, 1'b0);
        end
        finish_run();
        wait_done(2'd1, 1'b0);

        // start pulses mid-run: no restart, single done
        start_run(1'b0);
        strobe(200, 300, 500, 100, 1'b0);
        strobe(200, 300, 500, 100, 1'b1);
        strobe(200, 300, 500, 100, 1'b0);
        strobe(200, 300, 500, 100, 1'b0);
        finish_run();
        wait_done(2'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_restart_busy", {63'd0, busy}, 64'd0);
        end

        // second run: ch_sel moves 2 -> 3 only on DONE entry
        start_run(1'b0);
        repeat (4) strobe(0, 0, 0, 900, 1'b0);
        finish_run();
        wait_done(2'd2, 1'b0);

        // reset mid-run
        start_run(1'b0);
        strobe(5000, 0, 0, 0, 1'b0);
        strobe(5000, 0, 0, 0, 1'b0);
        Reset_l = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_ch_sel", {62'd0, ch_sel}, 64'd0);
        chk("midrst_best_val", 64'(best_val), 64'd0);
        chk("midrst_lock", {63'd0, lock}, 64'd0);
        tick();
        Reset_l = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("midrst_no_done", {63'd0, done}, 64'd0);
            tick();
        end

        // fresh run after reset
        start_run(1'b0);
        repeat (4) strobe(-1, -2, -3, -4, 1'b0);
        finish_run();
        wait_done(2'd0, 1'b0);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/crlb_chan_sched.md
Name: crlb_chan_sched

Overview:
- Acquisition controller for the four OQPSK correlator channels (crlb[0..3], exported as V0..V3).
- On a start request it accumulates the magnitude of each channel's correlation over NSYM symbol strobes, then serially compares the four sums.
- It reports the strongest channel (ch_sel), that channel's energy (best_val) and a lock flag against a threshold.
- Downstream, ch_sel drives the channel/bar selection; one run at a time, start/busy/done handshake.

Parameters:
- R, 7, sample width of modulator datapath.
- RINT, 4*R+1, width of each signed crlb input.
- NSYM, 16, symbol strobes accumulated per run (power of 2, >=2).
- CW, $clog2(NSYM)+1, strobe counter width.
- ACCW, RINT+$clog2(NSYM), unsigned accumulator width.
- THR, 1024, lock threshold (unsigned, ACCW bits).

Ports:
- C  in  1  clock, rising edge.
- Reset_l  in  1  asynchronous active-low reset.
- start  in  1  run request, level-sampled in IDLE only.
- sym_stb  in  1  one-cycle symbol strobe (from SH enable).
- crlb0..crlb3  in  RINT each  signed correlator outputs, valid when sym_stb=1.
- busy  out  1  high in CLEAR, ACCUM, COMPARE.
- done  out  1  one-cycle pulse at end of run.
- ch_sel  out  2  index of strongest channel.
- best_val  out  ACCW  accumulated magnitude of ch_sel.
- lock  out  1  best_val >= THR.

Behaviour:
- Reset (async, Reset_l=0): state=IDLE; busy=0, done=0, ch_sel=0, best_val=0, lock=0; accumulators, strobe counter and compare index cleared.
- FSM states: IDLE, CLEAR, ACCUM, COMPARE, DONE.
- IDLE -> CLEAR when start=1 at a clock edge.
- CLEAR (1 cycle): zero acc0..acc3 and strobe counter -> ACCUM. A sym_stb in CLEAR is ignored.
- ACCUM:
  - On each sym_stb, acc_k += |crlb_k| for all k in the same cycle; counter += 1.
  - |x| = -x for x<0, computed at RINT+1 bits, so -2^(RINT-1) yields 2^(RINT-1) with no wrap.
  - No overflow is possible by ACCW sizing.
  - On the cycle the NSYM-th strobe is accepted -> COMPARE next cycle.
  - Cycles without sym_stb hold all state.
- COMPARE (exactly 4 cycles, k=0..3):
  - k=0 loads cand_idx=0, cand_val=acc0.
  - k=1..3 replaces the candidate only if acc_k > cand_val (strict), so ties go to the lowest index.
  - -> DONE.
- DONE (1 cycle):
  - done=1.
  - ch_sel, best_val, lock registered from the candidate on DONE entry; lock = (cand_val >= THR).
  - -> IDLE.
- Outputs ch_sel/best_val/lock hold their values between runs and change only on DONE entry.
- Latency: done asserts 6 cycles after the edge accepting the NSYM-th strobe? No — COMPARE starts the cycle after that strobe; done asserts in the 5th cycle after it (4 COMPARE + DONE).
- Start-to-first-accumulate: start edge -> CLEAR -> ACCUM, so the earliest counted strobe is 2 cycles after start is sampled.
- start while busy or in DONE: ignored, not queued. start held high continuously launches a new run every time IDLE is reached.
- sym_stb during COMPARE/DONE/IDLE: ignored.
- Reset asserted mid-run: immediate return to reset values. The previous ch_sel/lock are lost (reset to 0) and no done pulse is emitted.

Test Plan:
- NSYM=4, THR=1024; start, then 4 strobes with crlb=(100,200,-300,50) -> done pulse 5 cycles after the 4th strobe, ch_sel=2, best_val=1200, lock=1, busy low after DONE.
- Tie: all crlb=77 for 4 strobes -> ch_sel=0, best_val=308, lock=0 (308<1024).
- Extreme: crlb1=-2^28 (RINT=29), others 0, 4 strobes -> ch_sel=1, best_val=2^30 exactly, no wrap.
- Gapped strobes: 4 strobes spaced 3..10 idle cycles, plus a strobe coincident with CLEAR -> CLEAR strobe not counted, sums equal 4 strobes only, done timing relative to last counted strobe.
- start pulsed during ACCUM and COMPARE -> no restart, single done. Then a second run with crlb=(0,0,0,900) -> ch_sel changes from 2 to 3 only on DONE entry.
- Reset_l=0 for 1 cycle after 2 strobes -> busy=0, ch_sel=0, best_val=0, lock=0 immediately; no done. A fresh run afterwards completes normally.
